// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: one WORD_W-bit ripple-carry slice is reused over NWORDS cycles, LSW first.
// Optional subtract mode is enabled with the RCA_SEQ_SUB_EN macro (adds port op_sub).
module rca_seq_ctrl #(
    parameter  int WORD_W  = 8,
    parameter  int NWORDS  = 4,
    localparam int TOTAL_W = WORD_W * NWORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] a,
    input  logic [TOTAL_W-1:0] b,
    input  logic               cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic               op_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] sum,
    output logic               carry,
    output logic               busy
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state, state_nx;
    logic [NWORDS-1:0][WORD_W-1:0]   opa, opb, sum_r;
    logic                            c_int, carry_r;
    logic [IW-1:0]                   idx;
    logic [WORD_W:0]                 slice;
    logic                            last;
    logic [TOTAL_W-1:0]              b_cap;
    logic                            c_cap;

    // B is stored pre-inverted with carry-in forced to 1 so the slice only ever adds.
`ifdef RCA_SEQ_SUB_EN
    assign b_cap = op_sub ? ~b : b;
    assign c_cap = op_sub ? 1'b1 : cin;
`else
    assign b_cap = b;
    assign c_cap = cin;
`endif

    assign slice = {1'b0, opa[idx]} + {1'b0, opb[idx]} + {{WORD_W{1'b0}}, c_int};
    assign last  = (idx == IW'(NWORDS - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            sum_r   <= '0;
            c_int   <= 1'b0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b_cap;
                        c_int <= c_cap;
                        idx   <= '0;
                        sum_r <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx] <= slice[WORD_W-1:0];
                    c_int      <= slice[WORD_W];
                    if (last) carry_r <= slice[WORD_W];
                    else      idx     <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: 4x8-bit instance for the main flow, 1x8-bit instance for the single-word case.
module tb_rca_seq_ctrl;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, op_sub = 1'b0;
    logic        in_ready, out_valid, carry, busy;
    logic [31:0] sum;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        cin1 = 1'b0;
    logic        in_ready1, out_valid1, carry1, busy1;
    logic [7:0]  sum1;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WORD_W(8), .NWORDS(NW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef RCA_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .busy(busy)
    );

    rca_seq_ctrl #(.WORD_W(8), .NWORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef RCA_SEQ_SUB_EN
        .op_sub(1'b0),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry(carry1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, scramble inputs after accept, optionally stall in DONE for 'hold' cycles.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                         input logic ts, input int hold);
        logic [32:0] e;
        int n;
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        a = ta; b = tb_v; cin = tc; op_sub = ts; in_valid = 1'b1;
        if (ts) e = {1'b0, ta} + {1'b0, ~tb_v} + 33'd1;
        else    e = {1'b0, ta} + {1'b0, tb_v} + {32'd0, tc};
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
        check("sum_clr", sum, 0);
        check("busy_run", busy, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NW + 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom;
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_sum", sum, sb[0][31:0]);
            check("hold_carry", carry, sb[0][32]);
        end
        check("done_ready", in_ready, 0);
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            check("sum", sum, e[31:0]);
            check("carry", carry, e[32]);
        end
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("ov_clr", out_valid, 0);
        check("ready_back", in_ready, 1);
        check("no_accept", busy, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        rst = 1'b0;

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 5);

        // Abort mid-RUN: rst sampled at the end of the second RUN cycle.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry, 0);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++)
            do_op($urandom, $urandom, 1'($urandom), 1'b0, 0);

`ifdef RCA_SEQ_SUB_EN
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0);
`endif

        // Single-word instance.
        @(negedge clk);
        a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w1_latency", n, 2);
        check("w1_sum", sum1, 8'h00);
        check("w1_carry", carry1, 1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1_ready", in_ready1, 1);
        check("w1_valid", out_valid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that time-shares one WORD_W-bit ripple-carry adder slice to add two TOTAL_W = WORD_W*NWORDS operands.
- Processes one word per cycle, least-significant word first, and registers the carry between words.
- Sits between a requester (valid/ready input side) and a consumer (valid/ready output side).
- Used wherever a full-width combinational adder is too slow or too large.

Parameters:
- WORD_W, 8, width of the shared adder slice in bits (>=1).
- NWORDS, 4, number of words per operand (>=1). TOTAL_W = WORD_W*NWORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  controller can accept operands.
- a  input  TOTAL_W  operand A.
- b  input  TOTAL_W  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  TOTAL_W  registered result.
- carry  output  1  registered carry out of the top word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry=0, word index=0, internal carry=0.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b into operand registers, internal carry<=cin, idx<=0, go to RUN. Clear sum to 0 on accept.
  - RUN: in_ready=0. Each cycle, {c,s} = a[idx] + b[idx] + internal carry (WORD_W+1-bit add). Write s into sum word idx; internal carry<=c. If idx==NWORDS-1: carry<=c, out_valid<=1, go to DONE. Otherwise idx<=idx+1.
  - DONE: out_valid=1; sum and carry held stable. On out_ready, out_valid<=0 and go to IDLE. No new accept is allowed in the same cycle as the out_ready handshake (in_ready=0 in DONE).
- Latency: accept on edge k, out_valid first high after edge k+NWORDS. Throughput: one operation per NWORDS+2 cycles when out_ready is held high.
- idx width is max(1,$clog2(NWORDS)). idx never exceeds NWORDS-1; no wrap-around in normal operation.
- NWORDS=1: RUN lasts one cycle, then DONE.
- Input changes on a, b, cin after accept have no effect on the result (operands are captured).
- in_valid while busy is ignored; no queueing.
- out_ready while not in DONE is ignored.
- Result is modular: sum = (a+b+cin) mod 2^TOTAL_W, carry = bit TOTAL_W of the full-precision sum.
- rst asserted in any state, including mid-RUN, aborts the operation and restores all reset values on that edge. rst has priority over every handshake.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), captured with the operands on accept.
  - When op_sub=1, the B operand is stored inverted and internal carry is initialised to 1 (cin is ignored), giving sum = a - b mod 2^TOTAL_W.
  - carry=1 means no borrow (a>=b unsigned).
- Not defined: port op_sub does not exist; addition only; behaviour exactly as above.

Test Plan:
- Defaults, reset then a=0xFFFFFFFF, b=0x00000001, cin=0 accepted at edge k -> out_valid rises after edge k+4; sum=0x00000000, carry=1.
- a=0x000000FF, b=0x00000001, cin=1 -> sum=0x00000101, carry=0. Confirms the word-0 carry propagates into word 1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing a/b -> out_valid stays 1, sum and carry unchanged, in_ready=0. Then out_ready=1 for one cycle -> IDLE, in_ready=1 on the next cycle.
- Assert rst on the 2nd RUN cycle of a=0x12345678, b=0x11111111 -> next cycle state=IDLE, sum=0, carry=0, out_valid=0. Then a fresh op 0x12345678+0x11111111 gives 0x23456789, carry=0.
- NWORDS=1, WORD_W=8: a=0x80, b=0x80, cin=0 -> out_valid after 1 cycle; sum=0x00, carry=1.
- With RCA_SEQ_SUB_EN defined: a=0x00000005, b=0x00000007, op_sub=1 -> sum=0xFFFFFFFE, carry=0. Then a=7, b=5 -> sum=0x00000002, carry=1.
